// File: rtl/fetch_issue_queue.sv
//==============================================================================
// Module      : fetch_issue_queue
// Description : Issues fetch-unit PCs to instruction memory under a credit limit,
//               queues in-order responses for decode, and drops stale responses
//               after a redirect from execute.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_issue_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] io_pc,
    output logic [XLEN-1:0] io_npc,
    output logic            io_npc_en,
    output logic            io_stall_en,
    input  logic            io_redirect_valid,
    input  logic [XLEN-1:0] io_redirect_target,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [XLEN-1:0] io_imem_resp_data,
    output logic            io_deq_valid,
    input  logic            io_deq_ready,
    output logic [XLEN-1:0] io_deq_pc,
    output logic [XLEN-1:0] io_deq_instr
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_PW + 1;
    localparam int c_SW = c_CW + 1;
    localparam logic [c_SW-1:0] c_DEPTH = c_SW'(DEPTH);

    logic [c_CW-1:0] r_inflight;
    logic [c_CW-1:0] r_drop_cnt;
    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] r_tag_wptr;
    logic [c_PW-1:0] r_tag_rptr;
    logic [c_PW-1:0] r_q_wptr;
    logic [c_PW-1:0] r_q_rptr;
    logic [XLEN-1:0] r_tag_mem [DEPTH];
    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic [XLEN-1:0] r_q_instr [DEPTH];

    logic [c_SW-1:0] w_credit;
    logic            w_fire;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;

    // Credit counts stale in-flight requests too, so a live response always has a slot.
    assign w_credit          = {1'b0, r_inflight} + {1'b0, r_count};
    assign io_imem_req_valid = !reset && !io_redirect_valid && (w_credit < c_DEPTH);
    assign io_imem_req_addr  = io_pc;
    assign w_fire            = io_imem_req_valid && io_imem_req_ready;
    assign io_stall_en       = !w_fire;

    assign io_npc            = io_redirect_target;
    assign io_npc_en         = io_redirect_valid && !reset;

    assign w_drop = io_imem_resp_valid && ((r_drop_cnt != '0) || io_redirect_valid);
    assign w_push = io_imem_resp_valid && !w_drop && !reset;
    assign w_pop  = (r_count != '0) && io_deq_ready && !io_redirect_valid;

    assign io_deq_valid = (r_count != '0);
    assign io_deq_pc    = r_q_pc[r_q_rptr];
    assign io_deq_instr = r_q_instr[r_q_rptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
            r_q_wptr   <= '0;
            r_q_rptr   <= '0;
        end else begin
            r_inflight <= r_inflight + c_CW'(w_fire) - c_CW'(io_imem_resp_valid);
            if (w_fire)
                r_tag_wptr <= r_tag_wptr + 1'b1;
            if (io_imem_resp_valid)
                r_tag_rptr <= r_tag_rptr + 1'b1;

            if (io_redirect_valid) begin
                // The response arriving now is already being discarded.
                r_drop_cnt <= r_inflight - c_CW'(io_imem_resp_valid);
                r_count    <= '0;
                r_q_rptr   <= r_q_wptr;
            end else begin
                if (io_imem_resp_valid && (r_drop_cnt != '0))
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
                if (w_push)
                    r_q_wptr <= r_q_wptr + 1'b1;
                if (w_pop)
                    r_q_rptr <= r_q_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_fire)
            r_tag_mem[r_tag_wptr] <= io_pc;
        if (w_push) begin
            r_q_pc[r_q_wptr]    <= r_tag_mem[r_tag_rptr];
            r_q_instr[r_q_wptr] <= io_imem_resp_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_issue_queue.sv
//==============================================================================
// Module      : tb_fetch_issue_queue
// Description : Randomized bench for fetch_issue_queue with a queue-based
//               reference model, a fetch-unit PC model and an in-order memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_issue_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic [XLEN-1:0] io_pc;
    logic [XLEN-1:0] io_npc;
    logic            io_npc_en;
    logic            io_stall_en;
    logic            io_redirect_valid;
    logic [XLEN-1:0] io_redirect_target;
    logic            io_imem_req_valid;
    logic            io_imem_req_ready;
    logic [XLEN-1:0] io_imem_req_addr;
    logic            io_imem_resp_valid;
    logic [XLEN-1:0] io_imem_resp_data;
    logic            io_deq_valid;
    logic            io_deq_ready;
    logic [XLEN-1:0] io_deq_pc;
    logic [XLEN-1:0] io_deq_instr;

    fetch_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
        .clock              (clock),
        .reset              (reset),
        .io_pc              (io_pc),
        .io_npc             (io_npc),
        .io_npc_en          (io_npc_en),
        .io_stall_en        (io_stall_en),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_target (io_redirect_target),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_deq_valid       (io_deq_valid),
        .io_deq_ready       (io_deq_ready),
        .io_deq_pc          (io_deq_pc),
        .io_deq_instr       (io_deq_instr)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        outst[$];   // requests accepted by memory, oldest first
    ent_t        dq[$];      // what decode should see, head first
    logic [31:0] fpc;        // fetch-unit PC register
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] pc);
        return (pc * 32'd3) ^ 32'h1357_9bdf;
    endfunction

    task automatic step(input bit rst, input bit redir, input bit rready,
                        input bit respv, input bit dready, input logic [31:0] tgt);
        bit   exp_req, fire, resp, live;
        ent_t e;
        req_t r;
        @(posedge clock);
        #1;
        resp                = respv && (outst.size() > 0);
        reset               = rst;
        io_redirect_valid   = redir;
        io_redirect_target  = tgt;
        io_imem_req_ready   = rready;
        io_imem_resp_valid  = resp;
        io_imem_resp_data   = resp ? mem_data(outst[0].pc) : 32'h0;
        io_deq_ready        = dready;
        io_pc               = fpc;
        #3;
        exp_req = !rst && !redir && ((outst.size() + dq.size()) < DEPTH);
        fire    = exp_req && rready;
        chk("req_valid", 32'(io_imem_req_valid), 32'(exp_req));
        chk("stall_en",  32'(io_stall_en),       32'(!fire));
        chk("npc_en",    32'(io_npc_en),         32'(redir && !rst));
        if (redir && !rst) chk("npc", io_npc, tgt);
        if (exp_req) chk("req_addr", io_imem_req_addr, fpc);
        chk("deq_valid", 32'(io_deq_valid), 32'(dq.size() != 0));
        if (dq.size() != 0) begin
            chk("deq_pc",    io_deq_pc,    dq[0].pc);
            chk("deq_instr", io_deq_instr, dq[0].instr);
        end

        if (rst) begin
            outst.delete();
            dq.delete();
            fpc = 32'h0;
            return;
        end
        live = 1'b0;
        if (resp) begin
            r = outst.pop_front();
            if (!r.stale && !redir) begin
                live = 1'b1;
                e.pc = r.pc;
                e.instr = mem_data(r.pc);
                chk("room_on_live_resp", 32'(dq.size() < DEPTH), 32'd1);
            end
        end
        if (redir) begin
            foreach (outst[i]) outst[i].stale = 1'b1;
            dq.delete();
            fpc = tgt;
        end else begin
            if (dq.size() != 0 && dready) void'(dq.pop_front());
            if (live) dq.push_back(e);
            if (fire) begin
                r.pc = fpc;
                r.stale = 1'b0;
                outst.push_back(r);
                fpc = fpc + 32'd4;
            end
        end
    endtask

    initial begin
        fpc                = 32'h0;
        reset              = 1'b1;
        io_pc              = 32'h0;
        io_redirect_valid  = 1'b0;
        io_redirect_target = 32'h0;
        io_imem_req_ready  = 1'b0;
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data  = 32'h0;
        io_deq_ready       = 1'b0;

        repeat (2) step(1, 0, 0, 0, 0, 32'h0);

        // Steady streaming: response one cycle after each request.
        repeat (30) step(0, 0, 1, 1, 1, 32'h0);

        // Decode stalls: queue fills, then one dequeue frees one credit.
        repeat (10) step(0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 1, 1, 32'h0);
        repeat (4) step(0, 0, 1, 1, 0, 32'h0);
        repeat (8) step(0, 0, 1, 1, 1, 32'h0);

        // Memory not ready for three cycles.
        repeat (3) step(0, 0, 0, 1, 1, 32'h0);
        repeat (6) step(0, 0, 1, 1, 1, 32'h0);

        // Redirect with inflight=2, count=1, no response in that cycle.
        step(1, 0, 0, 0, 0, 32'h0);
        repeat (3) step(0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 1, 0, 32'h0);
        step(0, 1, 1, 0, 1, 32'h100);
        repeat (12) step(0, 0, 1, 1, 1, 32'h0);

        // Redirect coinciding with a response while inflight=3.
        step(1, 0, 0, 0, 0, 32'h0);
        repeat (3) step(0, 0, 1, 0, 0, 32'h0);
        step(0, 1, 1, 1, 1, 32'h200);
        repeat (12) step(0, 0, 1, 1, 1, 32'h0);

        // Reset mid-operation together with a redirect and a response.
        repeat (3) step(0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 1, 0, 32'h0);
        step(1, 1, 1, 1, 1, 32'h300);
        repeat (6) step(0, 0, 1, 1, 1, 32'h0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 70),
                 {$urandom_range(0, 32'h3fff), 2'b00});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
- Sits between the PC-generating fetch unit and decode; it is the consumer end of the fetch unit's pc/npc/stall interface.
- Turns each presented io_pc into an instruction-memory request and drives back stall and redirect controls.
- Holds in-order responses in a small queue for decode.
- On a redirect from execute, flushes the queue and discards in-flight stale responses.

Parameters:
DEPTH, 4, max requests in flight plus queued entries (power of two, >=2)
XLEN, 32, PC and instruction width

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
io_pc  in  XLEN  current PC from fetch unit
io_npc  out  XLEN  redirect target to fetch unit
io_npc_en  out  1  redirect strobe to fetch unit
io_stall_en  out  1  hold PC at fetch unit
io_redirect_valid  in  1  redirect request from execute
io_redirect_target  in  XLEN  redirect target from execute
io_imem_req_valid  out  1  memory request valid
io_imem_req_ready  in  1  memory accepts request
io_imem_req_addr  out  XLEN  request address (= io_pc)
io_imem_resp_valid  in  1  response valid (in order, no backpressure)
io_imem_resp_data  in  XLEN  instruction word
io_deq_valid  out  1  queue head valid to decode
io_deq_ready  in  1  decode accepts head
io_deq_pc  out  XLEN  PC of head instruction
io_deq_instr  out  XLEN  head instruction

Behaviour:
- Decided: one clock `clock`; `reset` is synchronous, active-high.
- Reset:
  - count, inflight, drop_cnt and all queue/tag pointers go to 0.
  - io_deq_valid=0, io_imem_req_valid=0 and io_npc_en=0, each by combinational derivation.
  - Reset overrides everything, including a redirect or response in the same cycle; those are lost.
- State:
  - inflight (0..DEPTH): requests accepted and not yet answered, stale ones included.
  - drop_cnt (0..DEPTH): how many of inflight are stale.
  - Tag FIFO of DEPTH PCs: pushed on request fire, popped on every response.
  - Data queue of DEPTH {pc, instr} entries, with occupancy count.
- Redirect passthrough (combinational):
  - io_npc = io_redirect_target; io_npc_en = io_redirect_valid.
- Issue:
  - io_imem_req_valid = !reset && !io_redirect_valid && (inflight + count < DEPTH), using registered values only.
  - io_imem_req_addr = io_pc.
  - fire = req_valid && req_ready.
- Stall: io_stall_en = !fire. The PC advances only in a cycle where a request fires; when redirecting, npc_en takes priority at the fetch unit.
- Response handling, when resp_valid:
  - Pop the tag FIFO.
  - If drop_cnt>0 or io_redirect_valid: discard the data and decrement drop_cnt if it is >0.
  - Otherwise push {tag, data} into the data queue.
  - The credit rule guarantees the queue is never full on a live response; asserting otherwise is a bench check.
- Dequeue:
  - io_deq_valid = (count != 0); head fields come straight from registers (no bypass).
  - Pop on valid && ready.
  - Zero latency from memory to decode is not provided: a response is visible at io_deq_* the cycle after resp_valid.
- Redirect cycle:
  - Data queue flushed (count <= 0); any dequeue handshake that cycle is ignored.
  - drop_cnt <= inflight - resp_valid, because the response arriving this cycle is consumed as stale now.
  - No request issues.
  - A redirect while drop_cnt>0 recomputes drop_cnt by the same rule.
- inflight_next = inflight + fire - resp_valid.
  - resp_valid with inflight==0 is illegal (bench assertion).
- Simultaneous events:
  - fire + response + dequeue in one cycle all take effect.
  - Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then io_pc=0x0, req_ready=1, resp returned 1 cycle after each req, deq_ready=1:
  - requests issue for 0x0, 0x4, 0x8, ...
  - decode receives (0x0, data0) on the cycle after the first response, then one entry per cycle.
  - stall_en stays low in steady state.
- deq_ready=0, DEPTH=4:
  - after 4 fires, req_valid=0 and stall_en=1 with io_pc held at 0x10.
  - count=4; raising deq_ready for one cycle allows exactly one new fire, on the following cycle.
- req_ready=0 for 3 cycles:
  - stall_en=1 for those 3 cycles.
  - io_imem_req_addr holds the same PC.
  - no tag pushed.
- Redirect to 0x100 with inflight=2, count=1 and no response that cycle:
  - npc_en=1, npc=0x100.
  - queue empty next cycle.
  - the next 2 responses are discarded.
  - the first decoded PC afterward is 0x100.
- Redirect in the same cycle as a response, inflight=3:
  - drop_cnt becomes 2.
  - that response and the next two are discarded.
  - no stale PC ever reaches io_deq_pc.
- Assert reset mid-operation, with a redirect and a response in the same cycle:
  - next cycle count=0, inflight=0, drop_cnt=0.
  - deq_valid=0.
  - req_valid resumes once reset deasserts.
